// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

  localparam int unsigned INST_BYTES = 4;
  localparam int unsigned PC_W       = 64;
  localparam int unsigned INST_W     = 32;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] instruction;
  } fetch_entry_t;

  function automatic logic is_word_aligned(input logic [1:0] lsb);
    return lsb == 2'b00;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetched {pc, instruction} entries; flush beats push.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 2,
  localparam int unsigned AW   = $clog2(DEPTH),
  localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wr_data,
  output fetch_entry_t rd_data,
  output logic         full,
  output logic         empty,
  output logic [CW-1:0] count
);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == CW'(0));
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Storage clears on reset so the head reads as zero until the first push.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch front end: PC register, RUN/HALT control, redirect handling and fetch buffer.
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned         PC_WIDTH   = 64,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
  parameter int unsigned         FIFO_DEPTH = 2,
  parameter logic [PC_WIDTH-1:0] PROG_LIMIT = PC_WIDTH'(96)
) (
  input  logic                clk,
  input  logic                reset,
  output logic [PC_WIDTH-1:0] Inst_Address,
  input  logic [31:0]         Instruction,
  input  logic                redirect_valid,
  input  logic [PC_WIDTH-1:0] redirect_target,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [PC_WIDTH-1:0] out_pc,
  output logic [31:0]         out_instruction,
  output logic                halted,
  output logic                misalign_err
);

  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_e        state_q;
  fetch_state_e        state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q;
  logic [PC_WIDTH-1:0] pc_d;
  logic                misalign_d;
  logic [PC_WIDTH-1:0] pc_inc;
  logic [PC_WIDTH-1:0] pc_inc_end;
  logic [PC_WIDTH-1:0] target_end;

  logic                push;
  logic                pop;
  logic                flush;
  logic                space;
  logic                fifo_full;
  logic                fifo_empty;
  logic [CW-1:0]       fifo_count;
  fetch_entry_t        wr_entry;
  fetch_entry_t        head;

  assign Inst_Address    = fetch_pc_q;
  assign halted          = (state_q == HALT);
  assign out_valid       = !fifo_empty;
  assign out_pc          = PC_WIDTH'(head.pc);
  assign out_instruction = head.instruction;

  assign pop        = out_valid && out_ready;
  assign space      = (32'(fifo_count) < FIFO_DEPTH) || (fifo_full && pop);
  assign pc_inc     = fetch_pc_q + PC_WIDTH'(INST_BYTES);
  assign pc_inc_end = pc_inc + PC_WIDTH'(INST_BYTES);
  assign target_end = redirect_target + PC_WIDTH'(INST_BYTES);

  assign wr_entry.pc          = PC_W'(fetch_pc_q);
  assign wr_entry.instruction = Instruction;

  // Next state, next PC and buffer control; a redirect overrides any fetch.
  always_comb begin
    state_d    = state_q;
    pc_d       = fetch_pc_q;
    misalign_d = misalign_err;
    push       = 1'b0;
    flush      = 1'b0;
    if (redirect_valid) begin
      flush = 1'b1;
      pc_d  = redirect_target;
      if (!is_word_aligned(redirect_target[1:0])) begin
        misalign_d = 1'b1;
        state_d    = HALT;
      end else if (target_end > PROG_LIMIT) begin
        state_d = HALT;
      end else begin
        state_d = RUN;
      end
    end else if (state_q == RUN && space) begin
      push = 1'b1;
      pc_d = pc_inc;
      if (pc_inc_end > PROG_LIMIT) begin
        state_d = HALT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= RUN;
      fetch_pc_q   <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= pc_d;
      misalign_err <= misalign_d;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .pop     (pop),
    .flush   (flush),
    .wr_data (wr_entry),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit against a small combinational program memory.
module tb_instruction_fetch_unit;

  logic        clk;
  logic        reset;
  logic [63:0] inst_address;
  logic [31:0] instruction;
  logic        redirect_valid;
  logic [63:0] redirect_target;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_pc;
  logic [31:0] out_instruction;
  logic        halted;
  logic        misalign_err;

  int checks = 0;
  int errors = 0;
  int pc0_pops = 0;

  typedef struct {
    logic        rdy;
    logic        rv;
    logic [63:0] tgt;
    logic        e_valid;
    logic [63:0] e_pc;
    logic [63:0] e_addr;
  } vec_t;

  vec_t vecs [9];

  instruction_fetch_unit dut (
    .clk             (clk),
    .reset           (reset),
    .Inst_Address    (inst_address),
    .Instruction     (instruction),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_pc          (out_pc),
    .out_instruction (out_instruction),
    .halted          (halted),
    .misalign_err    (misalign_err)
  );

  // Standard program image: fixed words at known addresses, filler elsewhere.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    if (a >= 64'd96 || a[1:0] != 2'b00) return 32'h0000_0013;
    case (a)
      64'h00:  return 32'h0010_0313;
      64'h04:  return 32'h0040_0393;
      64'h20:  return 32'h04CA_4063;
      64'h24:  return 32'h0000_0693;
      64'h5C:  return 32'hFC00_02E3;
      default: return 32'h1000_0000 | a[31:0];
    endcase
  endfunction

  assign instruction = mem_word(inst_address);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (!reset && out_valid && out_ready && out_pc == 64'd0) pc0_pops++;
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [63:0] last_pc;
  logic [31:0] last_instr;
  logic        done;

  initial begin
    reset           = 1'b1;
    out_ready       = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = '0;

    vecs[0] = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h0,  64'h04};
    vecs[1] = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h0,  64'h08};
    vecs[2] = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h0,  64'h08};
    vecs[3] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h4,  64'h0C};
    vecs[4] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h8,  64'h10};
    vecs[5] = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h8,  64'h10};
    vecs[6] = '{1'b0, 1'b1, 64'h20, 1'b0, 64'h0,  64'h20};
    vecs[7] = '{1'b0, 1'b0, 64'h0,  1'b1, 64'h20, 64'h24};
    vecs[8] = '{1'b1, 1'b0, 64'h0,  1'b1, 64'h24, 64'h28};

    // Reset state, then first deliveries with decode always ready.
    step();
    step();
    chk("rst_addr",    inst_address, 64'h0);
    chk("rst_valid",   64'(out_valid), 64'h0);
    chk("rst_pc",      out_pc, 64'h0);
    chk("rst_instr",   64'(out_instruction), 64'h0);
    chk("rst_halted",  64'(halted), 64'h0);
    chk("rst_misalgn", 64'(misalign_err), 64'h0);
    reset = 1'b0;
    step();
    chk("first_valid", 64'(out_valid), 64'h1);
    chk("first_pc",    out_pc, 64'h0);
    chk("first_instr", 64'(out_instruction), 64'h0010_0313);
    step();
    chk("second_pc",    out_pc, 64'h4);
    chk("second_instr", 64'(out_instruction), 64'h0040_0393);

    // Back-pressure from reset, drain without gaps, redirect flushing a full buffer.
    reset     = 1'b1;
    out_ready = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) begin
      out_ready       = vecs[i].rdy;
      redirect_valid  = vecs[i].rv;
      redirect_target = vecs[i].tgt;
      step();
      chk($sformatf("vec%0d_valid", i), 64'(out_valid), 64'(vecs[i].e_valid));
      chk($sformatf("vec%0d_addr", i), inst_address, vecs[i].e_addr);
      if (vecs[i].e_valid) begin
        chk($sformatf("vec%0d_pc", i), out_pc, vecs[i].e_pc);
        chk($sformatf("vec%0d_instr", i), 64'(out_instruction), 64'(mem_word(vecs[i].e_pc)));
      end
    end
    redirect_valid = 1'b0;
    chk("redir_instr_0x20_seen", 64'(mem_word(64'h20)), 64'h04CA_4063);

    // Free run to the program limit.
    out_ready  = 1'b1;
    done       = 1'b0;
    last_pc    = '1;
    last_instr = '1;
    for (int i = 0; i < 60; i++) begin
      if (out_valid) begin
        last_pc    = out_pc;
        last_instr = out_instruction;
      end
      if (halted && !out_valid) begin
        done = 1'b1;
        break;
      end
      step();
    end
    chk("limit_reached", 64'(done), 64'h1);
    chk("limit_last_pc", last_pc, 64'd92);
    chk("limit_last_instr", 64'(last_instr), 64'hFC00_02E3);
    chk("limit_halted", 64'(halted), 64'h1);
    chk("limit_addr", inst_address, 64'd96);
    step();
    step();
    chk("limit_addr_hold", inst_address, 64'd96);
    chk("limit_no_push", 64'(out_valid), 64'h0);

    // Redirect out of HALT resumes fetching.
    redirect_valid  = 1'b1;
    redirect_target = 64'h24;
    step();
    redirect_valid = 1'b0;
    chk("resume_halted", 64'(halted), 64'h0);
    chk("resume_addr", inst_address, 64'h24);
    chk("resume_gap", 64'(out_valid), 64'h0);
    step();
    chk("resume_valid", 64'(out_valid), 64'h1);
    chk("resume_pc", out_pc, 64'h24);
    chk("resume_instr", 64'(out_instruction), 64'h0000_0693);

    // Misaligned redirect with entries buffered.
    out_ready = 1'b0;
    step();
    redirect_valid  = 1'b1;
    redirect_target = 64'h22;
    step();
    redirect_valid = 1'b0;
    chk("mis_err", 64'(misalign_err), 64'h1);
    chk("mis_halted", 64'(halted), 64'h1);
    chk("mis_flushed", 64'(out_valid), 64'h0);
    chk("mis_addr", inst_address, 64'h22);
    step();
    step();
    step();
    chk("mis_no_push", 64'(out_valid), 64'h0);
    chk("mis_sticky", 64'(misalign_err), 64'h1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("mis_rst_err", 64'(misalign_err), 64'h0);
    chk("mis_rst_halted", 64'(halted), 64'h0);
    chk("mis_rst_addr", inst_address, 64'h0);

    // Redirect coinciding with a head handshake on a full buffer.
    step();
    step();
    chk("hs_full_pc", out_pc, 64'h0);
    chk("hs_full_addr", inst_address, 64'h8);
    pc0_pops        = 0;
    out_ready       = 1'b1;
    redirect_valid  = 1'b1;
    redirect_target = 64'h40;
    step();
    redirect_valid = 1'b0;
    chk("hs_flushed", 64'(out_valid), 64'h0);
    chk("hs_addr", inst_address, 64'h40);
    step();
    chk("hs_next_valid", 64'(out_valid), 64'h1);
    chk("hs_next_pc", out_pc, 64'h40);
    step();
    chk("hs_follow_pc", out_pc, 64'h44);
    chk("hs_head_once", 64'(pc0_pops), 64'h1);

    // Reset mid-stream drops buffered entries.
    out_ready = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("midrst_valid", 64'(out_valid), 64'h0);
    chk("midrst_addr", inst_address, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
